ofmap_wr_idxcnt: RTL and testbench

OFMAP_WR_IDXCNT -- requirements
Module: ofmap_wr_idxcnt

---
 rtl/ofmap_wr_idxcnt.sv | 119 +++++++++++
 tb/tb_ofmap_wr_idxcnt.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_wr_idxcnt.sv
// ofmap_wr_idxcnt: five-level index counter chain that packs output-map elements into masked SRAM word writes.
module ofmap_wr_idxcnt #(
  parameter int IDX_W = 11,
  parameter int ADRA_W = 8,
  parameter int WOFS_W = 3,
  parameter int DATA_W = 16,
  localparam int NL = 1 << WOFS_W
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_cnt_clear,
  input  logic                 i_finalctx,
  input  logic [IDX_W-1:0]     i_xlim,
  input  logic [IDX_W-1:0]     i_xstep,
  input  logic [IDX_W-1:0]     i_ylim,
  input  logic [IDX_W-1:0]     i_ystep,
  input  logic [IDX_W-1:0]     i_klim,
  input  logic [IDX_W-1:0]     i_kstep,
  input  logic [IDX_W-1:0]     i_til_xlim,
  input  logic [IDX_W-1:0]     i_til_xstep,
  input  logic [IDX_W-1:0]     i_til_ylim,
  input  logic [IDX_W-1:0]     i_til_ystep,
  input  logic                 i_valid,
  input  logic [DATA_W-1:0]    i_data,
  output logic                 o_ready,
  output logic                 o_sram_wren,
  input  logic                 i_sram_gnt,
  output logic [ADRA_W-1:0]    o_sram_addr,
  output logic [DATA_W*NL-1:0] o_sram_wdata,
  output logic [NL-1:0]        o_sram_wmask,
  output logic                 o_done,
  output logic                 o_til_done
);
  typedef enum logic [1:0] {FILL, WAIT_GNT, FINISHED} state_t;
  state_t state, state_nxt;
  logic [4:0][IDX_W-1:0] lim, step, cnt, cnt_nxt;
  logic [4:0] flag, en;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [NL-1:0][DATA_W-1:0] dbuf;
  logic [NL-1:0] mask, mask_upd;
  logic [ADRA_W-1:0] addr;
  logic [WOFS_W-1:0] lane, lane_nxt;
  logic acc, flush, gnt, ctx_end, til_end, pend_done, pend_til;
  assign lim  = {i_til_ylim, i_til_xlim, i_klim, i_ylim, i_xlim};
  assign step = {i_til_ystep, i_til_xstep, i_kstep, i_ystep, i_xstep};
  assign o_ready = state == FILL;
  assign acc = i_valid & o_ready;
  assign gnt = state == WAIT_GNT & i_sram_gnt;
  always_comb begin
    logic run;
    run = acc;
    idx = '0;
    idx_nxt = '0;
    flag = '0;
    en = '0;
    cnt_nxt = cnt;
    for (int i = 0; i < 5; i++) begin
      flag[i] = ({1'b0, cnt[i]} + {1'b0, step[i]}) >= {1'b0, lim[i]};
      en[i] = run;
      run = run & flag[i];
      cnt_nxt[i] = en[i] ? (flag[i] ? '0 : cnt[i] + step[i]) : cnt[i];
      idx = idx + cnt[i];
      idx_nxt = idx_nxt + cnt_nxt[i];
    end
  end
  assign lane = idx[WOFS_W-1:0];
  assign lane_nxt = idx_nxt[WOFS_W-1:0];
  assign mask_upd = mask | (NL'(1) << lane);
  assign ctx_end = &flag[2:0];
  assign til_end = &flag;
  // A word is closed when the next element leaves it, would overwrite a filled lane, or the context ends.
  assign flush = acc & ((idx_nxt[IDX_W-1:WOFS_W] != idx[IDX_W-1:WOFS_W]) | mask_upd[lane_nxt] | ctx_end);
  always_comb begin
    state_nxt = (state == FILL && flush) ? WAIT_GNT
              : gnt ? ((pend_til & i_finalctx) ? FINISHED : FILL)
              : state;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= FILL;
      cnt <= '0;
      dbuf <= '0;
      mask <= '0;
      addr <= '0;
      pend_done <= 1'b0;
      pend_til <= 1'b0;
    end else if (i_cnt_clear) begin
      state <= FILL;
      cnt <= '0;
      dbuf <= '0;
      mask <= '0;
      addr <= '0;
      pend_done <= 1'b0;
      pend_til <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (acc) begin
        dbuf[lane] <= i_data;
        mask <= mask_upd;
        addr <= ADRA_W'(idx >> WOFS_W);
      end
      if (flush) begin
        pend_done <= ctx_end;
        pend_til <= til_end;
      end
      if (gnt) mask <= '0;
    end
  end
  assign o_sram_wren = state == WAIT_GNT;
  assign o_sram_addr = addr;
  assign o_sram_wmask = mask;
  assign o_done = gnt & pend_done & ~i_cnt_clear;
  assign o_til_done = gnt & pend_til & ~i_cnt_clear;
  always_comb begin
    o_sram_wdata = '0;
    for (int j = 0; j < NL; j++) o_sram_wdata[j*DATA_W +: DATA_W] = mask[j] ? dbuf[j] : '0;
  end
endmodule

// File: tb/tb_ofmap_wr_idxcnt.sv
// tb_ofmap_wr_idxcnt: directed scenarios for the ofmap write index counter with hand-computed words.
module tb_ofmap_wr_idxcnt;
  localparam int IDX_W = 11, ADRA_W = 8, WOFS_W = 3, DATA_W = 16, NL = 8;
  logic clk = 0, rstn = 0, clr = 0, finalctx = 0, valid = 0, gnt = 1;
  logic [IDX_W-1:0] xlim, xstep, ylim, ystep, klim, kstep, txlim, txstep, tylim, tystep;
  logic [DATA_W-1:0] data = '0;
  logic ready, wren, done, til_done;
  logic [ADRA_W-1:0] addr;
  logic [DATA_W*NL-1:0] wdata;
  logic [NL-1:0] wmask;
  logic [159:0] g, e;
  int tests = 0, fails = 0;
  localparam logic [127:0] W18 = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

  ofmap_wr_idxcnt #(.IDX_W(IDX_W), .ADRA_W(ADRA_W), .WOFS_W(WOFS_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_cnt_clear(clr), .i_finalctx(finalctx),
    .i_xlim(xlim), .i_xstep(xstep), .i_ylim(ylim), .i_ystep(ystep),
    .i_klim(klim), .i_kstep(kstep), .i_til_xlim(txlim), .i_til_xstep(txstep),
    .i_til_ylim(tylim), .i_til_ystep(tystep), .i_valid(valid), .i_data(data),
    .o_ready(ready), .o_sram_wren(wren), .i_sram_gnt(gnt), .o_sram_addr(addr),
    .o_sram_wdata(wdata), .o_sram_wmask(wmask), .o_done(done), .o_til_done(til_done)
  );

  always #5 clk = ~clk;

  task automatic cfg(input int xl, input int xs, input int yl, input int ys);
    xlim = IDX_W'(xl); xstep = IDX_W'(xs); ylim = IDX_W'(yl); ystep = IDX_W'(ys);
    klim = 1; kstep = 1; txlim = 1; txstep = 1; tylim = 1; tystep = 1;
  endtask

  task automatic clear_dut();
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      tests++; fails++;
      $display("FAIL push_timeout got ready=%b exp ready=1", ready);
    end
    valid = 1; data = d;
    @(negedge clk);
    valid = 0;
  endtask

  task automatic push_seq(input int first, input int count);
    for (int i = 0; i < count; i++) push(DATA_W'(first + i));
  endtask

  task automatic test_reset();
    #12;
    g = {ready, wren, addr, wdata, wmask, done, til_done};
    e = {1'b1, 1'b0, 8'h00, 128'h0, 8'h00, 1'b0, 1'b0};
    tests++; if (g !== e) begin fails++; $display("FAIL reset got %h exp %h", g, e); end
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_single_word();
    cfg(8, 1, 1, 1); clear_dut();
    push_seq(1, 8);
    g = {ready, wren, addr, wmask, wdata, done, til_done};
    e = {1'b0, 1'b1, 8'h00, 8'hFF, W18, 1'b1, 1'b1};
    tests++; if (g !== e) begin fails++; $display("FAIL single_word got %h exp %h", g, e); end
    @(negedge clk);
    g = {wren, ready, done, wmask}; e = {1'b0, 1'b1, 1'b0, 8'h00};
    tests++; if (g !== e) begin fails++; $display("FAIL single_word_after got %h exp %h", g, e); end
  endtask

  task automatic test_back_to_back();
    push_seq(11, 8);
    g = {wren, addr, wmask, wdata, done, til_done};
    e = {1'b1, 8'h00, 8'hFF, {16'd18, 16'd17, 16'd16, 16'd15, 16'd14, 16'd13, 16'd12, 16'd11}, 1'b1, 1'b1};
    tests++; if (g !== e) begin fails++; $display("FAIL back_to_back got %h exp %h", g, e); end
    @(negedge clk);
  endtask

  task automatic test_two_words();
    cfg(12, 1, 1, 1); clear_dut();
    push_seq(1, 8);
    g = {wren, addr, wmask, wdata, done, til_done};
    e = {1'b1, 8'h00, 8'hFF, W18, 1'b0, 1'b0};
    tests++; if (g !== e) begin fails++; $display("FAIL two_words_first got %h exp %h", g, e); end
    @(negedge clk);
    push_seq(9, 4);
    g = {wren, addr, wmask, wdata, done, til_done};
    e = {1'b1, 8'h01, 8'h0F, {64'h0, 16'd12, 16'd11, 16'd10, 16'd9}, 1'b1, 1'b1};
    tests++; if (g !== e) begin fails++; $display("FAIL two_words_second got %h exp %h", g, e); end
    @(negedge clk);
  endtask

  task automatic test_stride();
    cfg(8, 2, 1, 1); clear_dut();
    push_seq(1, 4);
    g = {wren, addr, wmask, wdata, done, til_done};
    e = {1'b1, 8'h00, 8'h55, {16'h0, 16'd4, 16'h0, 16'd3, 16'h0, 16'd2, 16'h0, 16'd1}, 1'b1, 1'b1};
    tests++; if (g !== e) begin fails++; $display("FAIL stride got %h exp %h", g, e); end
    @(negedge clk);
  endtask

  task automatic test_lane_collision();
    cfg(2, 1, 2, 1); clear_dut();
    push_seq(1, 2);
    g = {wren, addr, wmask, wdata, done, til_done};
    e = {1'b1, 8'h00, 8'h03, {96'h0, 16'd2, 16'd1}, 1'b0, 1'b0};
    tests++; if (g !== e) begin fails++; $display("FAIL collision_first got %h exp %h", g, e); end
    @(negedge clk);
    push_seq(3, 2);
    g = {wren, addr, wmask, wdata, done, til_done};
    e = {1'b1, 8'h00, 8'h06, {80'h0, 16'd4, 16'd3, 16'h0}, 1'b1, 1'b1};
    tests++; if (g !== e) begin fails++; $display("FAIL collision_second got %h exp %h", g, e); end
    @(negedge clk);
  endtask

  task automatic test_gnt_stall();
    cfg(8, 1, 1, 1); clear_dut();
    gnt = 0;
    push_seq(1, 8);
    for (int i = 0; i < 5; i++) begin
      valid = 1; data = 16'hDEAD;
      if (i == 4) gnt = 1;
      #1;
      g = {wren, ready, addr, wmask, wdata};
      e = {1'b1, 1'b0, 8'h00, 8'hFF, W18};
      tests++; if (g !== e) begin fails++; $display("FAIL stall_hold_%0d got %h exp %h", i, g, e); end
      g = {done, til_done}; e = (i == 4) ? 2'b11 : 2'b00;
      tests++; if (g !== e) begin fails++; $display("FAIL stall_done_%0d got %h exp %h", i, g, e); end
      @(negedge clk);
    end
    valid = 0;
    g = {wren, ready, wmask, done}; e = {1'b0, 1'b1, 8'h00, 1'b0};
    tests++; if (g !== e) begin fails++; $display("FAIL stall_release got %h exp %h", g, e); end
  endtask

  task automatic test_finalctx();
    cfg(8, 1, 1, 1); clear_dut();
    finalctx = 1;
    push_seq(1, 8);
    g = {done, til_done}; e = 2'b11;
    tests++; if (g !== e) begin fails++; $display("FAIL final_done got %h exp %h", g, e); end
    @(negedge clk);
    valid = 1; data = 16'h0BAD;
    for (int i = 0; i < 3; i++) begin
      g = {ready, wren}; e = 2'b00;
      tests++; if (g !== e) begin fails++; $display("FAIL finished_%0d got %h exp %h", i, g, e); end
      @(negedge clk);
    end
    valid = 0; finalctx = 0;
    clear_dut();
    g = {ready, wren, wmask}; e = {1'b1, 1'b0, 8'h00};
    tests++; if (g !== e) begin fails++; $display("FAIL final_clear got %h exp %h", g, e); end
    push_seq(21, 8);
    g = {wren, addr, wmask, wdata};
    e = {1'b1, 8'h00, 8'hFF, {16'd28, 16'd27, 16'd26, 16'd25, 16'd24, 16'd23, 16'd22, 16'd21}};
    tests++; if (g !== e) begin fails++; $display("FAIL final_restart got %h exp %h", g, e); end
    @(negedge clk);
  endtask

  task automatic test_clear_wait();
    cfg(8, 1, 1, 1); clear_dut();
    gnt = 0;
    push_seq(1, 8);
    g = {wren, wmask}; e = {1'b1, 8'hFF};
    tests++; if (g !== e) begin fails++; $display("FAIL clear_pending got %h exp %h", g, e); end
    clr = 1; gnt = 1;
    #1;
    g = {done, til_done}; e = 2'b00;
    tests++; if (g !== e) begin fails++; $display("FAIL clear_no_done got %h exp %h", g, e); end
    @(negedge clk);
    clr = 0;
    g = {wren, wmask, wdata, ready, done}; e = {1'b0, 8'h00, 128'h0, 1'b1, 1'b0};
    tests++; if (g !== e) begin fails++; $display("FAIL clear_wait got %h exp %h", g, e); end
    push_seq(31, 8);
    g = {wren, addr, wmask, done};
    e = {1'b1, 8'h00, 8'hFF, 1'b1};
    tests++; if (g !== e) begin fails++; $display("FAIL clear_restart got %h exp %h", g, e); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    cfg(8, 1, 1, 1); clear_dut();
    push_seq(1, 3);
    #2 rstn = 0;
    #1;
    g = {wren, wmask, ready, wdata}; e = {1'b0, 8'h00, 1'b1, 128'h0};
    tests++; if (g !== e) begin fails++; $display("FAIL async_reset got %h exp %h", g, e); end
    @(negedge clk);
    rstn = 1;
    push_seq(41, 8);
    g = {wren, addr, wmask, wdata};
    e = {1'b1, 8'h00, 8'hFF, {16'd48, 16'd47, 16'd46, 16'd45, 16'd44, 16'd43, 16'd42, 16'd41}};
    tests++; if (g !== e) begin fails++; $display("FAIL async_restart got %h exp %h", g, e); end
    @(negedge clk);
  endtask

  initial begin
    cfg(8, 1, 1, 1);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_two_words();
    test_stride();
    test_lane_collision();
    test_gnt_stall();
    test_finalctx();
    test_clear_wait();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
